// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle MIPS core.
// Fetch FSM encoding, reset instruction and exception codes.
package cpu_defs;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_DRAIN = 3'd3,
        FS_DONE  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_INST = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL   = 5'h04;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: issues one SRAM-like request per fetch_start,
// holds the instruction register, and flags misaligned PCs.
module inst_fetch_unit
    import cpu_defs::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_INST = cpu_defs::RESET_INST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_data_ok,
    output logic [DATA_W-1:0] instruction,
    output logic              fetch_done,
    output logic              fetch_busy,
    output logic              adel_ex,
    output logic [ADDR_W-1:0] bad_vaddr
);

    fetch_state_e      state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] inst_q;
    logic              done_q;
    logic              adel_q;
    logic [ADDR_W-1:0] badva_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FS_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            inst_q  <= RESET_INST;
            done_q  <= 1'b0;
            adel_q  <= 1'b0;
            badva_q <= '0;
        end else begin
            done_q <= 1'b0;
            adel_q <= 1'b0;
            unique case (state_q)
                FS_IDLE: begin
                    if (fetch_start) begin
                        if (pc[1:0] != 2'b00) begin
                            adel_q  <= 1'b1;
                            badva_q <= pc;
                        end else begin
                            addr_q  <= pc;
                            req_q   <= 1'b1;
                            state_q <= FS_REQ;
                        end
                    end
                end
                FS_REQ: begin
                    // Once accepted, a response is owed even if flushed.
                    if (inst_addr_ok) begin
                        req_q <= 1'b0;
                        if (flush) begin
                            state_q <= inst_data_ok ? FS_IDLE : FS_DRAIN;
                        end else if (inst_data_ok) begin
                            inst_q  <= inst_rdata;
                            done_q  <= 1'b1;
                            state_q <= FS_DONE;
                        end else begin
                            state_q <= FS_WAIT;
                        end
                    end else if (flush) begin
                        req_q   <= 1'b0;
                        state_q <= FS_IDLE;
                    end
                end
                FS_WAIT: begin
                    if (flush) begin
                        state_q <= inst_data_ok ? FS_IDLE : FS_DRAIN;
                    end else if (inst_data_ok) begin
                        inst_q  <= inst_rdata;
                        done_q  <= 1'b1;
                        state_q <= FS_DONE;
                    end
                end
                FS_DRAIN: begin
                    if (inst_data_ok) begin
                        state_q <= FS_IDLE;
                    end
                end
                FS_DONE: begin
                    state_q <= FS_IDLE;
                end
                default: begin
                    state_q <= FS_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign inst_req    = req_q;
    assign inst_addr   = addr_q;
    assign instruction = inst_q;
    assign fetch_done  = done_q;
    assign fetch_busy  = (state_q != FS_IDLE);
    assign adel_ex     = adel_q;
    assign bad_vaddr   = badva_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        flush;
    logic [31:0] pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic [31:0] instruction;
    logic        fetch_done;
    logic        fetch_busy;
    logic        adel_ex;
    logic [31:0] bad_vaddr;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    inst_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .flush       (flush),
        .pc          (pc),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_rdata  (inst_rdata),
        .inst_data_ok(inst_data_ok),
        .instruction (instruction),
        .fetch_done  (fetch_done),
        .fetch_busy  (fetch_busy),
        .adel_ex     (adel_ex),
        .bad_vaddr   (bad_vaddr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fetch_done) done_cnt++;
        if (inst_req && inst_addr_ok) acc_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; fetch_start = 1'b0; flush = 1'b0; pc = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        step(); step();
        total++;
        if (inst_req !== 1'b0 || inst_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_req req=%b addr=%h want 0/0", inst_req, inst_addr);
        end
        total++;
        if (instruction !== 32'h0 || fetch_done !== 1'b0 || adel_ex !== 1'b0) begin
            bad++;
            $display("FAIL reset_out inst=%h done=%b adel=%b want 0", instruction, fetch_done, adel_ex);
        end
        total++;
        if (bad_vaddr !== 32'h0 || fetch_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_misc bva=%h busy=%b want 0", bad_vaddr, fetch_busy);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_zero_wait();
        pc = 32'hbfc00000; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        total++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000 || fetch_busy !== 1'b1) begin
            bad++;
            $display("FAIL zw_req req=%b addr=%h busy=%b want 1/bfc00000/1", inst_req, inst_addr, fetch_busy);
        end
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        total++;
        if (inst_req !== 1'b0 || fetch_done !== 1'b0) begin
            bad++;
            $display("FAIL zw_wait req=%b done=%b want 0/0", inst_req, fetch_done);
        end
        inst_data_ok = 1'b1; inst_rdata = 32'h24080001;
        step();
        inst_data_ok = 1'b0;
        total++;
        if (fetch_done !== 1'b1 || instruction !== 32'h24080001) begin
            bad++;
            $display("FAIL zw_done done=%b inst=%h want 1/24080001", fetch_done, instruction);
        end
        step();
        total++;
        if (fetch_done !== 1'b0 || fetch_busy !== 1'b0) begin
            bad++;
            $display("FAIL zw_idle done=%b busy=%b want 0/0", fetch_done, fetch_busy);
        end
    endtask

    task automatic test_wait_states();
        int d0 = done_cnt;
        int errs = 0;
        pc = 32'hbfc00010; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        pc = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010 || fetch_busy !== 1'b1) errs++;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL ws_req_hold errors=%0d want 0", errs);
        end
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (inst_req !== 1'b0 || fetch_busy !== 1'b1 || fetch_done !== 1'b0) errs++;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL ws_wait errors=%0d want 0", errs);
        end
        inst_data_ok = 1'b1; inst_rdata = 32'h8c020000;
        step();
        inst_data_ok = 1'b0;
        total++;
        if (fetch_done !== 1'b1 || instruction !== 32'h8c020000) begin
            bad++;
            $display("FAIL ws_done done=%b inst=%h want 1/8c020000", fetch_done, instruction);
        end
        step();
        total++;
        if (done_cnt - d0 != 1 || fetch_busy !== 1'b0) begin
            bad++;
            $display("FAIL ws_count dones=%0d busy=%b want 1/0", done_cnt - d0, fetch_busy);
        end
    endtask

    task automatic test_misaligned();
        int a0 = acc_cnt;
        pc = 32'hbfc00002; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        total++;
        if (adel_ex !== 1'b1 || bad_vaddr !== 32'hbfc00002) begin
            bad++;
            $display("FAIL mis_adel adel=%b bva=%h want 1/bfc00002", adel_ex, bad_vaddr);
        end
        total++;
        if (inst_req !== 1'b0 || fetch_busy !== 1'b0 || instruction !== 32'h8c020000) begin
            bad++;
            $display("FAIL mis_side req=%b busy=%b inst=%h want 0/0/8c020000", inst_req, fetch_busy, instruction);
        end
        step();
        total++;
        if (adel_ex !== 1'b0 || bad_vaddr !== 32'hbfc00002 || acc_cnt != a0) begin
            bad++;
            $display("FAIL mis_after adel=%b bva=%h acc=%0d want 0/bfc00002/0", adel_ex, bad_vaddr, acc_cnt - a0);
        end
    endtask

    task automatic test_flush_wait();
        int d0 = done_cnt;
        pc = 32'hbfc00008; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (fetch_busy !== 1'b1 || inst_req !== 1'b0) begin
            bad++;
            $display("FAIL fl_drain busy=%b req=%b want 1/0", fetch_busy, inst_req);
        end
        step();
        inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
        step();
        inst_data_ok = 1'b0;
        total++;
        if (instruction !== 32'h8c020000 || fetch_done !== 1'b0 || fetch_busy !== 1'b0) begin
            bad++;
            $display("FAIL fl_discard inst=%h done=%b busy=%b want 8c020000/0/0", instruction, fetch_done, fetch_busy);
        end
        pc = 32'hbfc00004; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        total++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00004) begin
            bad++;
            $display("FAIL fl_refetch_req req=%b addr=%h want 1/bfc00004", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d8000;
        step();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        total++;
        if (fetch_done !== 1'b1 || instruction !== 32'h3c1d8000 || done_cnt != d0) begin
            bad++;
            $display("FAIL fl_refetch done=%b inst=%h prior_dones=%0d want 1/3c1d8000/0", fetch_done, instruction, done_cnt - d0);
        end
        step();
    endtask

    task automatic test_reset_mid();
        pc = 32'hbfc00020; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        total++;
        if (inst_req !== 1'b1) begin
            bad++;
            $display("FAIL rm_req req=%b want 1", inst_req);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        total++;
        if (inst_req !== 1'b0 || instruction !== 32'h0 || fetch_busy !== 1'b0 || inst_addr !== 32'h0) begin
            bad++;
            $display("FAIL rm_state req=%b inst=%h busy=%b addr=%h want 0/0/0/0", inst_req, instruction, fetch_busy, inst_addr);
        end
        step();
    endtask

    task automatic test_ignored_start();
        int d0 = done_cnt;
        int a0 = acc_cnt;
        pc = 32'hbfc00030; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        pc = 32'hbfc00040; fetch_start = 1'b1;
        step(); step();
        fetch_start = 1'b0;
        total++;
        if (inst_req !== 1'b0 || fetch_busy !== 1'b1) begin
            bad++;
            $display("FAIL ig_wait req=%b busy=%b want 0/1", inst_req, fetch_busy);
        end
        inst_data_ok = 1'b1; inst_rdata = 32'h00001234;
        step();
        inst_data_ok = 1'b0;
        total++;
        if (fetch_done !== 1'b1 || instruction !== 32'h00001234) begin
            bad++;
            $display("FAIL ig_done done=%b inst=%h want 1/00001234", fetch_done, instruction);
        end
        step(); step();
        total++;
        if (acc_cnt - a0 != 1 || done_cnt - d0 != 1 || inst_req !== 1'b0) begin
            bad++;
            $display("FAIL ig_count acc=%0d dones=%0d req=%b want 1/1/0", acc_cnt - a0, done_cnt - d0, inst_req);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_misaligned();
        test_flush_wait();
        test_reset_mid();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Fetch-side partner of the PC generator in the multi-cycle MIPS core. It takes the current PC, issues a request on the SRAM-like instruction-memory interface, and waits for the response. It holds the returned word in the instruction register, which drives the PC generator's immediate and jump fields and the decoder. It signals completion so main control can assert pc_write, and it flags misaligned fetch addresses.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
RESET_INST, 32'h00000000, instruction register value after reset (MIPS nop)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
fetch_start  in  1  pulse from main control: fetch at pc
flush  in  1  abandon the current fetch (exception/redirect)
pc  in  ADDR_W  current PC from the PC generator
inst_req  out  1  memory request valid
inst_addr  out  ADDR_W  memory request address
inst_addr_ok  in  1  memory accepted the request this cycle
inst_rdata  in  DATA_W  memory read data
inst_data_ok  in  1  inst_rdata valid this cycle
instruction  out  DATA_W  instruction register
fetch_done  out  1  one-cycle pulse: instruction updated
fetch_busy  out  1  high in any state other than IDLE
adel_ex  out  1  one-cycle pulse: misaligned fetch address
bad_vaddr  out  ADDR_W  faulting PC, held until the next adel_ex

Behaviour:
- Reset (clk edge with reset==0): state=IDLE, inst_req=0, inst_addr=0, instruction=RESET_INST, fetch_done=0, adel_ex=0, bad_vaddr=0. Reset overrides every other input. Any in-flight transaction is abandoned without a drain; the memory model must also be reset.
- States: IDLE, REQ, WAIT, DRAIN, DONE. All outputs are registered.
- IDLE:
  - fetch_start=1, pc[1:0]!=0: adel_ex=1 next cycle, bad_vaddr<=pc, instruction unchanged, stay IDLE.
  - fetch_start=1, pc aligned: addr_q<=pc, go REQ. inst_req rises in the next cycle.
- REQ:
  - inst_req=1, inst_addr=addr_q; both are held stable until inst_addr_ok.
  - addr_ok && data_ok in the same cycle: capture inst_rdata, go DONE.
  - addr_ok only: go WAIT; inst_req drops next cycle.
  - flush before addr_ok: drop inst_req, go IDLE. No transaction is outstanding.
- WAIT:
  - data_ok: instruction<=inst_rdata, go DONE.
  - flush (without data_ok): go DRAIN.
  - flush and data_ok together: discard the data, go IDLE.
- DRAIN: the one outstanding response is discarded on data_ok, then go IDLE. instruction is not updated. fetch_start is ignored.
- DONE: fetch_done=1 for exactly one cycle, then IDLE. Latency from fetch_start to fetch_done with zero-wait memory is 3 cycles: REQ, WAIT/DONE transition, DONE.
- fetch_start outside IDLE is ignored, with no queuing.
- flush in IDLE or DONE has no effect; fetch_done still pulses.
- At most one outstanding transaction; inst_req is never asserted in WAIT or DRAIN.
- inst_addr is word-aligned by construction; the pc value is not sampled after IDLE.

Decomposition:
- Shared package (cpu_defs): fetch state encoding (3-bit), RESET_INST, exception code constant EXC_ADEL=5'h04.
- Single module, no sub-module. The memory-side handshake is simple enough to stay inline.

Test Plan:
- Zero-wait fetch: reset released, pc=32'hbfc00000, fetch_start pulse, memory gives addr_ok at once and data_ok=1 with rdata=32'h24080001 next cycle -> inst_req high 1 cycle, addr=bfc00000, instruction=24080001, fetch_done pulses 3 cycles after start.
- Wait states: addr_ok held low 4 cycles, then data_ok delayed 3 cycles -> inst_req/inst_addr stable throughout, single fetch_done, fetch_busy high the whole time.
- Misaligned: pc=32'hbfc00002, fetch_start -> adel_ex pulse, bad_vaddr=bfc00002, inst_req never asserted, instruction unchanged.
- Flush in WAIT: flush asserted after addr_ok, data_ok later with rdata=32'hdeadbeef -> instruction keeps its old value, no fetch_done. A following fetch at bfc00004 returns its own data correctly.
- Reset mid-fetch: reset low during REQ -> next cycle inst_req=0, instruction=0, state IDLE.
- Ignored start: extra fetch_start pulses during WAIT -> exactly one memory request and one fetch_done.
